phy_rx_sync_ctrl: RTL and testbench
===================================

// Module: phy_rx_sync_ctrl
// PURPOSE
//  Receive-side synchronisation controller for the PHY serial lane. It consumes the 1-bit stream from
//  the rx input flop stage at clk_8f, hunts for the COMMA character, and declares the lane active after
//  LOCK_COUNT aligned commas. Once active, it frames and emits parallel bytes to the deserialiser/unstriping logic.
// PARAMETERS
//  COMMA       8'hBC  sync character; MSB received first
//  IDLE        8'h7C  filler character; framed but never marked valid
//  LOCK_COUNT  4      consecutive aligned COMMAs required to assert active (range 1..15)
// PORTS
//  clk_8f     in   1  bit clock; one serial bit per rising edge
//  reset      in   1  asynchronous, active-low; 0 = reset
//  data_in    in   1  serial bit from rx flop stage
//  resync     in   1  synchronous request to drop lock and return to HUNT
//  data_out   out  8  last framed data byte
//  valid_out  out  1  1-cycle pulse: data_out carries a new non-COMMA/non-IDLE byte
//  active     out  1  lane locked
//  comma_cnt  out  4  aligned COMMAs counted in ALIGN; saturates at LOCK_COUNT
// BEHAVIOUR
//  - reset=0, asynchronous: state=HUNT, sr=0, bit_cnt=0, data_out=0, valid_out=0, active=0, comma_cnt=0.
//  - Shifter: sr <= {sr[6:0], data_in} every cycle in all states. cand = {sr[6:0], data_in}.
//  - HUNT: each cycle, if cand==COMMA -> ALIGN, comma_cnt=1, bit_cnt=0; arbitrary bit alignment is accepted.
//    If LOCK_COUNT==1, go directly to LOCKED and set active=1.
//  - ALIGN: bit_cnt increments 0..7 and wraps. When bit_cnt==7, cand is a byte:
//    cand==COMMA -> comma_cnt+1; when comma_cnt reaches LOCK_COUNT -> LOCKED, active=1 on the same edge.
//    cand!=COMMA -> HUNT, comma_cnt=0. Nothing is emitted in ALIGN.
//  - LOCKED: bit_cnt free-runs mod 8. When bit_cnt==7: data_out<=cand. valid_out<=1 unless cand is COMMA or IDLE.
//    Latency: the byte is visible on the edge that samples its last bit (LSB). valid_out is high for exactly one cycle.
//    data_out holds its last value between bytes and after COMMA/IDLE bytes (these do not update data_out).
//    LOCKED persists until resync or reset; in-band data never drops lock.
//  - resync=1 at any edge, in any state: ->HUNT, active=0, comma_cnt=0, bit_cnt=0, valid_out=0. resync has priority
//    over byte completion on that edge. sr keeps shifting, so a COMMA spanning resync is detectable the next cycle.
//  - Reset mid-byte or mid-lock: immediate clear, as above; the partial byte is discarded.
//  - comma_cnt is 4-bit unsigned and never exceeds LOCK_COUNT. bit_cnt is 3-bit and wraps 7->0.
// STRUCTURE
//  - Shared package phy_pkg holds COMMA/IDLE defaults and the state encoding (HUNT=2'd0, ALIGN=2'd1, LOCKED=2'd2).
//  - One sub-module: phy_rx_shift8 (8-bit serial-in shifter with async active-low clear, exposes cand).
//  - The FSM, counters and output registers stay in this module.
// TESTING
//  1 Reset: hold reset=0 while toggling data_in -> all outputs 0. Release -> HUNT, active=0.
//  2 Misaligned lock: 3 random bits, then 4x 8'hBC -> comma_cnt 1,2,3,4; active rises on last BC's LSB edge; no valid_out.
//  3 Data framing: after lock, send 8'hA5, 8'h7C, 8'h3C -> valid_out pulses for A5 and 3C only; data_out=A5 then 3C.
//  4 Broken alignment: 2x BC, then 8'h00 -> back to HUNT, comma_cnt=0, active stays 0.
//  5 resync while locked, asserted on the LSB edge of byte 8'h11 -> no valid_out, active=0, HUNT;
//    4x BC afterwards -> relock.
//  6 Async reset mid-byte in LOCKED (bit_cnt=3) -> outputs clear before the next edge; relock needs 4 fresh BCs.

Source files
------------

// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
//  Shared definitions for the PHY receive lane:
//   - default COMMA / IDLE characters and the default lock threshold
//   - receive synchroniser state encoding
//   - is_fill(): true for characters that are framed but never reported as data
// No ports (package).
// -----------------------------------------------------------------------------
package phy_pkg;

   localparam logic [7:0] COMMA_DEF      = 8'hBC;
   localparam logic [7:0] IDLE_DEF       = 8'h7C;
   localparam int         LOCK_COUNT_DEF = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic is_fill(input logic [7:0] b,
                                    input logic [7:0] comma,
                                    input logic [7:0] idle);
      return (b == comma) || (b == idle);
   endfunction

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// phy_rx_sync_ctrl_if
//  Bundles the serial input, the framed byte output and the lock status of the
//  receive synchroniser.
//   data_in      serial bit from the rx flop stage
//   resync       synchronous request to drop lock and go back to HUNT
//   data_out     last framed data byte
//   valid_out    one-cycle pulse, data_out carries a new data byte
//   active       lane locked
//   comma_cnt    aligned COMMAs counted in ALIGN
//   state_dbg    FSM state, for observation only
//   bit_cnt_dbg  bit position inside the current byte, for observation only
//   sr_dbg       raw shift register contents, for observation only
//  Handshake: valid_out is a strobe without backpressure. The consumer must
//  capture data_out in the cycle valid_out is high; there is no ready.
//  Modports: slave = synchroniser side, master = upstream/downstream side.
// -----------------------------------------------------------------------------
interface phy_rx_sync_ctrl_if;
   import phy_pkg::*;

   logic       data_in;
   logic       resync;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic [3:0] comma_cnt;
   state_t     state_dbg;
   logic [2:0] bit_cnt_dbg;
   logic [7:0] sr_dbg;

   modport slave (
      input  data_in, resync,
      output data_out, valid_out, active, comma_cnt,
             state_dbg, bit_cnt_dbg, sr_dbg
   );

   modport master (
      output data_in, resync,
      input  data_out, valid_out, active, comma_cnt,
             state_dbg, bit_cnt_dbg, sr_dbg
   );

endinterface

// File: rtl/phy_rx_shift8.sv
// -----------------------------------------------------------------------------
// phy_rx_shift8
//  8-bit serial-in shift register, MSB first. Shifts one bit per clk_8f edge
//  regardless of the state of the consumer.
//   clk_8f  in   bit clock
//   reset   in   asynchronous active-low clear
//   din     in   serial bit
//   sr      out  registered history of the last 8 bits
//   cand    out  byte that would be in sr after this edge: {sr[6:0], din}
// -----------------------------------------------------------------------------
module phy_rx_shift8 (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       din,
   output logic [7:0] sr,
   output logic [7:0] cand
);

   // cand is combinational so a character is recognised on the very edge that
   // samples its last bit.
   assign cand = {sr[6:0], din};

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) sr <= 8'h00;
      else        sr <= cand;
   end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_sync_ctrl
//  Receive synchroniser for the PHY serial lane. Hunts for COMMA at any bit
//  offset, confirms LOCK_COUNT byte-aligned COMMAs, then frames the stream into
//  bytes and strobes every byte that is neither COMMA nor IDLE.
//   clk_8f  in   bit clock, one serial bit per rising edge
//   reset   in   asynchronous active-low reset
//   bus     slave modport of phy_rx_sync_ctrl_if (see interface header)
//  Parameters: COMMA, IDLE (characters), LOCK_COUNT (1..15).
// -----------------------------------------------------------------------------
module phy_rx_sync_ctrl
   import phy_pkg::*;
#(
   parameter logic [7:0] COMMA      = COMMA_DEF,
   parameter logic [7:0] IDLE       = IDLE_DEF,
   parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
   input  logic                   clk_8f,
   input  logic                   reset,
   phy_rx_sync_ctrl_if.slave      bus
);

   localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

   logic [7:0] sr;
   logic [7:0] cand;

   state_t     state, state_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [3:0] comma_cnt, comma_nxt;
   logic       active_q, active_nxt;
   logic [7:0] data_q, data_nxt;
   logic       valid_q, valid_nxt;
   logic       byte_done;

   phy_rx_shift8 u_shift (
      .clk_8f (clk_8f),
      .reset  (reset),
      .din    (bus.data_in),
      .sr     (sr),
      .cand   (cand)
   );

   // bit_cnt==7 means the current edge samples the LSB, so cand is a whole
   // byte aligned to the framing established by the first COMMA.
   assign byte_done = (bit_cnt == 3'd7);

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt + 3'd1;
      comma_nxt   = comma_cnt;
      active_nxt  = active_q;
      data_nxt    = data_q;
      valid_nxt   = 1'b0;

      if (bus.resync) begin
         // Wins over a byte completing on the same edge.
         state_nxt   = HUNT;
         bit_cnt_nxt = 3'd0;
         comma_nxt   = 4'd0;
         active_nxt  = 1'b0;
      end else begin
         case (state)
            HUNT: begin
               bit_cnt_nxt = 3'd0;
               if (cand == COMMA) begin
                  // The COMMA's LSB lands on this edge: the next bit starts a byte.
                  comma_nxt = 4'd1;
                  if (LOCK_CNT4 == 4'd1) begin
                     state_nxt  = LOCKED;
                     active_nxt = 1'b1;
                  end else begin
                     state_nxt = ALIGN;
                  end
               end
            end
            ALIGN: begin
               if (byte_done) begin
                  if (cand == COMMA) begin
                     comma_nxt = comma_cnt + 4'd1;
                     if (comma_cnt + 4'd1 == LOCK_CNT4) begin
                        state_nxt  = LOCKED;
                        active_nxt = 1'b1;
                     end
                  end else begin
                     state_nxt   = HUNT;
                     bit_cnt_nxt = 3'd0;
                     comma_nxt   = 4'd0;
                  end
               end
            end
            LOCKED: begin
               // In-band characters never drop lock; fill characters are
               // swallowed without touching data_out.
               if (byte_done && !is_fill(cand, COMMA, IDLE)) begin
                  data_nxt  = cand;
                  valid_nxt = 1'b1;
               end
            end
            default: begin
               state_nxt   = HUNT;
               bit_cnt_nxt = 3'd0;
               comma_nxt   = 4'd0;
               active_nxt  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state     <= HUNT;
         bit_cnt   <= 3'd0;
         comma_cnt <= 4'd0;
         active_q  <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         comma_cnt <= comma_nxt;
         active_q  <= active_nxt;
         data_q    <= data_nxt;
         valid_q   <= valid_nxt;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.valid_out   = valid_q;
   assign bus.active      = active_q;
   assign bus.comma_cnt   = comma_cnt;
   assign bus.state_dbg   = state;
   assign bus.bit_cnt_dbg = bit_cnt;
   assign bus.sr_dbg      = sr;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_sync_ctrl
//  Directed bench for phy_rx_sync_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_phy_rx_sync_ctrl;
   import phy_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_8f;
   logic reset;

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   phy_rx_sync_ctrl_if bus ();

   phy_rx_sync_ctrl u_dut (
      .clk_8f (clk_8f),
      .reset  (reset),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Drive a bit, let one rising edge sample it, return 1 time unit later.
   task automatic send_bit(input logic b, input logic rs);
      bus.data_in = b;
      bus.resync  = rs;
      @(posedge clk_8f);
      #1;
      bus.resync  = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input int msb, input int lsb);
      for (int i = msb; i >= lsb; i--) send_bit(b[i], 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 7, 0);
   endtask

   task automatic chk_lock(input string tag, input logic [3:0] cnt, input logic act,
                           input state_t st);
      chk({tag, "_cnt"},   32'(bus.comma_cnt), 32'(cnt));
      chk({tag, "_act"},   32'(bus.active),    32'(act));
      chk({tag, "_state"}, 32'(bus.state_dbg), 32'(st));
      chk({tag, "_valid"}, 32'(bus.valid_out), 32'h0);
   endtask

   logic [7:0] toggles;

   initial begin
      reset       = 1'b0;
      bus.data_in = 1'b0;
      bus.resync  = 1'b0;
      toggles     = 8'b1011_0101;

      // 1: reset held while data toggles
      for (int i = 0; i < 6; i++) send_bit(toggles[i], 1'b0);
      chk("rst_dout",  32'(bus.data_out),    32'h0);
      chk("rst_valid", 32'(bus.valid_out),   32'h0);
      chk("rst_act",   32'(bus.active),      32'h0);
      chk("rst_cnt",   32'(bus.comma_cnt),   32'h0);
      chk("rst_sr",    32'(bus.sr_dbg),      32'h0);
      chk("rst_bcnt",  32'(bus.bit_cnt_dbg), 32'h0);
      reset = 1'b1;
      #1;
      chk("rel_state", 32'(bus.state_dbg), 32'(HUNT));
      chk("rel_act",   32'(bus.active),    32'h0);

      // 2: three stray bits, then four COMMAs at an odd offset
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      chk_lock("pre", 4'd0, 1'b0, HUNT);
      send_byte(8'hBC);
      chk_lock("bc1", 4'd1, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("bc2", 4'd2, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("bc3", 4'd3, 1'b0, ALIGN);
      send_bits(8'hBC, 7, 1);
      chk_lock("bc4_pre", 4'd3, 1'b0, ALIGN);
      send_bits(8'hBC, 0, 0);
      chk_lock("bc4", 4'd4, 1'b1, LOCKED);

      // 3: data framing, IDLE swallowed
      send_byte(8'hA5);
      chk("a5_valid", 32'(bus.valid_out), 32'h1);
      chk("a5_dout",  32'(bus.data_out),  32'hA5);
      send_bits(8'h7C, 7, 7);
      chk("a5_pulse", 32'(bus.valid_out), 32'h0);
      send_bits(8'h7C, 6, 0);
      chk("idle_valid", 32'(bus.valid_out), 32'h0);
      chk("idle_dout",  32'(bus.data_out),  32'hA5);
      send_byte(8'h3C);
      chk("3c_valid", 32'(bus.valid_out), 32'h1);
      chk("3c_dout",  32'(bus.data_out),  32'h3C);
      chk("3c_act",   32'(bus.active),    32'h1);

      // 4: drop lock, then a broken alignment attempt
      send_bit(1'b0, 1'b1);
      chk_lock("rs1", 4'd0, 1'b0, HUNT);
      chk("rs1_bcnt", 32'(bus.bit_cnt_dbg), 32'h0);
      send_byte(8'hBC);
      chk_lock("brk1", 4'd1, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("brk2", 4'd2, 1'b0, ALIGN);
      send_byte(8'h00);
      chk_lock("brk3", 4'd0, 1'b0, HUNT);

      // 5: lock, resync on the LSB edge of 0x11, relock
      for (int k = 1; k <= 4; k++) send_byte(8'hBC);
      chk_lock("lk5", 4'd4, 1'b1, LOCKED);
      send_bits(8'h11, 7, 1);
      send_bit(1'b1, 1'b1);
      chk_lock("rs5", 4'd0, 1'b0, HUNT);
      chk("rs5_dout", 32'(bus.data_out), 32'h3C);
      for (int k = 1; k <= 4; k++) send_byte(8'hBC);
      chk_lock("relk5", 4'd4, 1'b1, LOCKED);

      // 6: asynchronous reset three bits into a byte
      send_byte(8'hA5);
      chk("6a5_valid", 32'(bus.valid_out), 32'h1);
      chk("6a5_dout",  32'(bus.data_out),  32'hA5);
      send_bits(8'hF0, 7, 5);
      chk("6_bcnt", 32'(bus.bit_cnt_dbg), 32'h3);
      #2;
      reset = 1'b0;
      #1;
      chk("6_dout",  32'(bus.data_out),    32'h0);
      chk("6_bcnt0", 32'(bus.bit_cnt_dbg), 32'h0);
      chk_lock("6rst", 4'd0, 1'b0, HUNT);
      #1;
      reset = 1'b1;
      send_byte(8'hBC);
      chk_lock("6bc1", 4'd1, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("6bc2", 4'd2, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("6bc3", 4'd3, 1'b0, ALIGN);
      send_byte(8'hBC);
      chk_lock("6bc4", 4'd4, 1'b1, LOCKED);
      send_byte(8'h5A);
      chk("6_5a_valid", 32'(bus.valid_out), 32'h1);
      chk("6_5a_dout",  32'(bus.data_out),  32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
